// File: rtl/mem_stage_param_pkg.sv
// Shared definitions for the memory stage: access-size codes, byte-lane
// enable generation and the alignment rule.
// Latency: n/a (package). Backpressure: n/a.
package mem_stage_param_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_DBL  = 2'b11;

  // Widest supported data word is 64 bits, i.e. 8 byte lanes.
  localparam int MAX_LANES = 8;

  // Byte-lane mask for an access of the given size starting at lane 'off'.
  // Callers keep only the low DATA_W/8 bits.
  function automatic logic [MAX_LANES-1:0] byte_en(input logic [1:0] size,
                                                   input logic [2:0] off);
    logic [MAX_LANES:0] run;
    run = (9'd1 << (4'd1 << size)) - 9'd1;
    return run[MAX_LANES-1:0] << off;
  endfunction

  // An access is misaligned if it is wider than the data word, or if the
  // address is not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [2:0] addr_lo,
                                      input int         data_w);
    logic [2:0] amask;
    if ((8 << size) > data_w) return 1'b1;
    case (size)
      SZ_BYTE: amask = 3'b000;
      SZ_HALF: amask = 3'b001;
      SZ_WORD: amask = 3'b011;
      SZ_DBL:  amask = 3'b111;
      default: amask = 3'b111;
    endcase
    return |(addr_lo & amask);
  endfunction

endpackage

// File: rtl/mem_stage_param_dm_ram.sv
// dm_ram: single-port synchronous data RAM with per-byte write enables.
// Latency: read data valid one clk edge after en; output holds while en=0.
// Backpressure: none; caller gates en. Ports: clk, en, be, idx, wdata, rdata.
module dm_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic [DATA_W/8-1:0]        be,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Contents and read register are deliberately not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/mem_stage_param.sv
// Memory pipeline stage: loads/stores against a local data RAM, ALU pass-through.
// Latency: one clk4 edge from ex inputs to dm outputs.
// Backpressure: stall=1 freezes every register and disables the RAM.
// Ports: clk4/rst_n; ex-side controls (valid/mem_en/mem_we/size/unsigned/
// mem_sel), ans_ex (ALU result + byte address), b_bypass (store data), rd_ex;
// err_clr; dm-side valid/rd/result/misalign and sticky alignment error.
module mem_stage_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8,
  parameter int RD_W   = 5
) (
  input  logic              clk4,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              valid_ex,
  input  logic              mem_en_ex,
  input  logic              mem_we_ex,
  input  logic [1:0]        size_ex,
  input  logic              unsigned_ex,
  input  logic              mem_sel_ex,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] b_bypass,
  input  logic [RD_W-1:0]   rd_ex,
  input  logic              err_clr,
  output logic              valid_dm,
  output logic [RD_W-1:0]   rd_dm,
  output logic [DATA_W-1:0] result_dm,
  output logic              misalign_dm,
  output logic              err_sticky
);

  import mem_stage_param_pkg::*;

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = ADDR_W - OFF_W;
  localparam int DEPTH = 1 << IDX_W;

  // ---------------- execute-side decode ----------------
  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic              access;
  logic              mis_now;
  logic [MAX_LANES-1:0] be_full;
  logic              ram_en;
  logic [NB-1:0]     ram_be;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_bits;

  assign off     = ans_ex[OFF_W-1:0];
  assign idx     = ans_ex[ADDR_W-1:OFF_W];
  assign access  = valid_ex & mem_en_ex & ~stall;
  assign mis_now = access & misaligned(size_ex, ans_ex[2:0], DATA_W);
  assign be_full = byte_en(size_ex, 3'(off));

  // rst_n gating keeps a store that coincides with reset assertion out of the RAM.
  assign ram_en    = access & rst_n;
  assign ram_be    = (mem_we_ex & ~mis_now & rst_n) ? be_full[NB-1:0] : '0;
  assign ram_wdata = b_bypass << {off, 3'b000};

  // Upper ALU bits are not part of the address; upper lane-mask bits are
  // beyond this word width.
  assign unused_bits = ^{ans_ex, be_full};

  dm_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_dm_ram (
    .clk   (clk4),
    .en    (ram_en),
    .be    (ram_be),
    .idx   (idx),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // ---------------- pipeline registers ----------------
  logic              valid_r;
  logic [DATA_W-1:0] ans_r;
  logic              mem_sel_r;
  logic              we_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [OFF_W-1:0]  off_r;

  always_ff @(posedge clk4 or negedge rst_n) begin
    if (!rst_n) begin
      valid_r     <= 1'b0;
      rd_dm       <= '0;
      ans_r       <= '0;
      mem_sel_r   <= 1'b0;
      we_r        <= 1'b0;
      size_r      <= SZ_BYTE;
      uns_r       <= 1'b0;
      off_r       <= '0;
      misalign_dm <= 1'b0;
      err_sticky  <= 1'b0;
    end else if (!stall) begin
      valid_r     <= valid_ex;
      rd_dm       <= rd_ex;
      ans_r       <= ans_ex;
      mem_sel_r   <= mem_sel_ex;
      we_r        <= mem_we_ex;
      size_r      <= size_ex;
      uns_r       <= unsigned_ex;
      off_r       <= off;
      misalign_dm <= mis_now;
      // A new misalignment wins over a same-edge clear.
      err_sticky  <= (err_sticky & ~err_clr) | mis_now;
    end
  end

  assign valid_dm = valid_r;

  // ---------------- load alignment and extension ----------------
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] load_ext;
  logic              sign_bit;
  int                load_bits;

  always_comb begin
    shifted   = ram_rdata >> {off_r, 3'b000};
    load_bits = 8 << size_r;
    sign_bit  = 1'b0;
    load_ext  = '0;
    // Oversized accesses are always misaligned and return 0, so a missing
    // sign bit for them is harmless.
    for (int i = 0; i < DATA_W; i++) begin
      if (i == load_bits - 1) sign_bit = shifted[i];
    end
    for (int i = 0; i < DATA_W; i++) begin
      load_ext[i] = (i < load_bits) ? shifted[i] : (sign_bit & ~uns_r);
    end
  end

  // RAM output holds while stalled, so result_dm is stable across a stall.
  always_comb begin
    result_dm = ans_r;
    if (mem_sel_r && !we_r) result_dm = misalign_dm ? '0 : load_ext;
  end

endmodule

// File: tb/tb_mem_stage_param.sv
module tb_mem_stage_param;
  import mem_stage_param_pkg::*;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int RD_W   = 5;

  logic        clk4 = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, valid_ex = 1'b0, mem_en_ex = 1'b0, mem_we_ex = 1'b0;
  logic [1:0]  size_ex = 2'b00;
  logic        unsigned_ex = 1'b0, mem_sel_ex = 1'b0, err_clr = 1'b0;
  logic [31:0] ans_ex = '0, b_bypass = '0;
  logic [4:0]  rd_ex = '0;
  logic        valid_dm, misalign_dm, err_sticky;
  logic [4:0]  rd_dm;
  logic [31:0] result_dm;

  int checks = 0;
  int errors = 0;

  // Reference model: byte-addressed memory plus expected outputs.
  logic [7:0]  mm [256];
  logic        exp_valid = 1'b0, exp_mis = 1'b0, exp_err = 1'b0;
  logic [4:0]  exp_rd = '0;
  logic [31:0] exp_res = '0;

  mem_stage_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W)) dut (
    .clk4(clk4), .rst_n(rst_n), .stall(stall), .valid_ex(valid_ex),
    .mem_en_ex(mem_en_ex), .mem_we_ex(mem_we_ex), .size_ex(size_ex),
    .unsigned_ex(unsigned_ex), .mem_sel_ex(mem_sel_ex), .ans_ex(ans_ex),
    .b_bypass(b_bypass), .rd_ex(rd_ex), .err_clr(err_clr),
    .valid_dm(valid_dm), .rd_dm(rd_dm), .result_dm(result_dm),
    .misalign_dm(misalign_dm), .err_sticky(err_sticky)
  );

  always #5 clk4 = ~clk4;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "timeout");
  end

  function automatic bit model_mis(int addr, int size);
    int n = 1 << size;
    if (n > DATA_W / 8) return 1'b1;
    return (addr % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(int addr, int size, bit uns);
    int n = 1 << size;
    longint v = 0;
    for (int k = 0; k < n; k++) v += longint'(mm[addr + k]) << (8 * k);
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  // Drives one ex-slot, advances one edge and updates the model expectations.
  task automatic drive(input bit v, me, we, input bit [1:0] sz, input bit un, sel,
                       input logic [31:0] ans, b, input logic [4:0] rd,
                       input bit clr, stl);
    int addr;
    bit acc, mis;
    valid_ex = v; mem_en_ex = me; mem_we_ex = we; size_ex = sz; unsigned_ex = un;
    mem_sel_ex = sel; ans_ex = ans; b_bypass = b; rd_ex = rd; err_clr = clr; stall = stl;
    if (!stl) begin
      addr = int'(ans[7:0]);
      acc  = v && me;
      mis  = acc && model_mis(addr, int'(sz));
      if (acc && we && !mis)
        for (int k = 0; k < (1 << sz); k++) mm[addr + k] = b[8*k +: 8];
      exp_valid = v;
      exp_rd    = rd;
      exp_mis   = mis;
      if (sel && !we) exp_res = mis ? 32'd0 : model_load(addr, int'(sz), un);
      else            exp_res = ans;
      exp_err = (exp_err && !clr) || mis;
    end
    @(posedge clk4); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk4);
    #1;
    checks++; if (valid_dm !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid_dm); end
    checks++; if (rd_dm !== 5'd0) begin errors++; $display("FAIL reset_rd got=%h want=0", rd_dm); end
    checks++; if (result_dm !== 32'd0) begin errors++; $display("FAIL reset_result got=%h want=0", result_dm); end
    checks++; if (misalign_dm !== 1'b0) begin errors++; $display("FAIL reset_misalign got=%b want=0", misalign_dm); end
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL reset_err got=%b want=0", err_sticky); end
    @(negedge clk4);
    rst_n = 1'b1;
  endtask

  task automatic init_mem();
    for (int w = 0; w < 64; w++) drive(1, 1, 1, SZ_WORD, 0, 0, 32'(w * 4), $urandom, 5'd0, 0, 0);
  endtask

  task automatic test_word_store_load();
    drive(1, 1, 1, SZ_WORD, 0, 0, 32'h10, 32'hDEADBEEF, 5'd1, 0, 0);
    checks++; if (result_dm !== 32'h10) begin errors++; $display("FAIL store_pass result=%h want=%h", result_dm, 32'h10); end
    drive(1, 1, 0, SZ_WORD, 0, 1, 32'h10, 32'h0, 5'd3, 0, 0);
    checks++; if (result_dm !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load result=%h want=deadbeef", result_dm); end
    checks++; if (valid_dm !== 1'b1 || rd_dm !== 5'd3) begin errors++; $display("FAIL word_load_ctl valid=%b rd=%h want 1/3", valid_dm, rd_dm); end
    drive(1, 1, 0, SZ_BYTE, 0, 1, 32'h13, 32'h0, 5'd2, 0, 0);
    checks++; if (result_dm !== 32'hFFFFFFDE) begin errors++; $display("FAIL byte_signed result=%h want=ffffffde", result_dm); end
    drive(1, 1, 0, SZ_BYTE, 1, 1, 32'h13, 32'h0, 5'd2, 0, 0);
    checks++; if (result_dm !== 32'h000000DE) begin errors++; $display("FAIL byte_unsigned result=%h want=000000de", result_dm); end
    drive(1, 1, 1, SZ_HALF, 0, 0, 32'h12, 32'hAAAA1234, 5'd2, 0, 0);
    drive(1, 1, 0, SZ_WORD, 0, 1, 32'h10, 32'h0, 5'd2, 0, 0);
    checks++; if (result_dm !== 32'h1234BEEF) begin errors++; $display("FAIL half_store result=%h want=1234beef", result_dm); end
    drive(1, 1, 0, SZ_HALF, 0, 1, 32'h12, 32'h0, 5'd2, 0, 0);
    checks++; if (result_dm !== 32'h00001234) begin errors++; $display("FAIL half_load result=%h want=00001234", result_dm); end
  endtask

  task automatic test_misalign();
    drive(1, 1, 0, SZ_WORD, 0, 1, 32'h11, 32'h0, 5'd8, 0, 0);
    checks++; if (misalign_dm !== 1'b1) begin errors++; $display("FAIL mis_load_flag got=%b want=1", misalign_dm); end
    checks++; if (result_dm !== 32'd0) begin errors++; $display("FAIL mis_load_result got=%h want=0", result_dm); end
    checks++; if (err_sticky !== 1'b1) begin errors++; $display("FAIL mis_sticky got=%b want=1", err_sticky); end
    drive(1, 0, 0, SZ_WORD, 0, 0, 32'h55, 32'h0, 5'd8, 0, 0);
    checks++; if (misalign_dm !== 1'b0 || err_sticky !== 1'b1) begin errors++; $display("FAIL mis_one_cycle mis=%b err=%b want 0/1", misalign_dm, err_sticky); end
    checks++; if (result_dm !== 32'h55) begin errors++; $display("FAIL alu_pass result=%h want=55", result_dm); end
    drive(1, 1, 1, SZ_WORD, 0, 0, 32'h11, 32'hFFFFFFFF, 5'd8, 0, 0);
    checks++; if (misalign_dm !== 1'b1) begin errors++; $display("FAIL mis_store_flag got=%b want=1", misalign_dm); end
    drive(1, 1, 0, SZ_DBL, 0, 1, 32'h18, 32'h0, 5'd8, 0, 0);
    checks++; if (misalign_dm !== 1'b1 || result_dm !== 32'd0) begin errors++; $display("FAIL dbl_oversize mis=%b result=%h want 1/0", misalign_dm, result_dm); end
    drive(1, 1, 0, SZ_WORD, 0, 1, 32'h10, 32'h0, 5'd8, 0, 0);
    checks++; if (result_dm !== 32'h1234BEEF) begin errors++; $display("FAIL mis_mem_unchanged result=%h want=1234beef", result_dm); end
    drive(0, 0, 0, SZ_BYTE, 0, 0, 32'h0, 32'h0, 5'd0, 1, 0);
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL err_clr got=%b want=0", err_sticky); end
  endtask

  task automatic test_set_wins();
    drive(1, 1, 0, SZ_HALF, 0, 1, 32'h13, 32'h0, 5'd1, 1, 0);
    checks++; if (err_sticky !== 1'b1 || misalign_dm !== 1'b1) begin errors++; $display("FAIL set_wins err=%b mis=%b want 1/1", err_sticky, misalign_dm); end
    drive(0, 0, 0, SZ_BYTE, 0, 0, 32'h0, 32'h0, 5'd0, 1, 0);
    checks++; if (err_sticky !== 1'b0) begin errors++; $display("FAIL set_wins_clear got=%b want=0", err_sticky); end
  endtask

  task automatic test_stall();
    drive(1, 1, 0, SZ_WORD, 0, 1, 32'h10, 32'h0, 5'd4, 0, 0);
    checks++; if (result_dm !== 32'h1234BEEF) begin errors++; $display("FAIL pre_stall result=%h want=1234beef", result_dm); end
    for (int c = 0; c < 3; c++) begin
      if (c < 2) drive(1, 1, 0, SZ_WORD, 0, 1, 32'h20, 32'h0, 5'd5, 0, 1);
      else       drive(1, 1, 1, SZ_WORD, 0, 0, 32'h10, 32'h0, 5'd6, 0, 1);
      checks++; if (result_dm !== 32'h1234BEEF || rd_dm !== 5'd4 || valid_dm !== 1'b1) begin
        errors++; $display("FAIL stall_hold cyc=%0d result=%h rd=%h valid=%b want 1234beef/4/1", c, result_dm, rd_dm, valid_dm); end
    end
    drive(1, 1, 0, SZ_WORD, 0, 1, 32'h20, 32'h0, 5'd5, 0, 0);
    checks++; if (result_dm !== exp_res || rd_dm !== 5'd5) begin errors++; $display("FAIL stall_release result=%h rd=%h want %h/5", result_dm, rd_dm, exp_res); end
    drive(1, 1, 0, SZ_WORD, 0, 1, 32'h10, 32'h0, 5'd5, 0, 0);
    checks++; if (result_dm !== 32'h1234BEEF) begin errors++; $display("FAIL stall_no_write result=%h want=1234beef", result_dm); end
  endtask

  task automatic test_max_addr();
    drive(1, 1, 1, SZ_BYTE, 0, 0, 32'hFF, 32'h000000A5, 5'd1, 0, 0);
    drive(1, 1, 0, SZ_BYTE, 1, 1, 32'hFF, 32'h0, 5'd1, 0, 0);
    checks++; if (result_dm !== 32'h000000A5) begin errors++; $display("FAIL max_byte_u result=%h want=000000a5", result_dm); end
    drive(1, 1, 0, SZ_BYTE, 0, 1, 32'hFF, 32'h0, 5'd1, 0, 0);
    checks++; if (result_dm !== 32'hFFFFFFA5) begin errors++; $display("FAIL max_byte_s result=%h want=ffffffa5", result_dm); end
    drive(1, 1, 0, SZ_WORD, 0, 1, 32'hFC, 32'h0, 5'd1, 0, 0);
    checks++; if (result_dm[31:24] !== 8'hA5 || result_dm !== exp_res) begin errors++; $display("FAIL max_word result=%h want=%h", result_dm, exp_res); end
  endtask

  task automatic test_reset_mid();
    drive(1, 1, 1, SZ_WORD, 0, 0, 32'h20, 32'h11223344, 5'd7, 0, 0);
    valid_ex = 1; mem_en_ex = 1; mem_we_ex = 1; size_ex = SZ_WORD; mem_sel_ex = 0;
    ans_ex = 32'h20; b_bypass = 32'h99999999; rd_ex = 5'd9; err_clr = 0; stall = 0;
    rst_n = 1'b0;
    #1;
    checks++; if (valid_dm !== 1'b0 || rd_dm !== 5'd0 || result_dm !== 32'd0 || misalign_dm !== 1'b0 || err_sticky !== 1'b0) begin
      errors++; $display("FAIL midreset_async valid=%b rd=%h result=%h mis=%b err=%b want all 0", valid_dm, rd_dm, result_dm, misalign_dm, err_sticky); end
    @(posedge clk4); #1;
    checks++; if (valid_dm !== 1'b0 || result_dm !== 32'd0) begin errors++; $display("FAIL midreset_hold valid=%b result=%h want 0/0", valid_dm, result_dm); end
    rst_n = 1'b1;
    exp_valid = 0; exp_rd = '0; exp_res = '0; exp_mis = 0; exp_err = 0;
    drive(1, 1, 0, SZ_WORD, 0, 1, 32'h20, 32'h0, 5'd7, 0, 0);
    checks++; if (result_dm !== 32'h11223344) begin errors++; $display("FAIL midreset_store_blocked result=%h want=11223344", result_dm); end
  endtask

  task automatic test_random();
    bit v, me, we, un, sel, clr, stl;
    bit [1:0] sz;
    for (int n = 0; n < 400; n++) begin
      v   = $urandom_range(0, 9) != 0;
      me  = $urandom_range(0, 3) != 0;
      we  = $urandom_range(0, 1) != 0;
      sz  = 2'($urandom_range(0, 3));
      un  = $urandom_range(0, 1) != 0;
      sel = (v && me) ? ($urandom_range(0, 1) != 0) : 1'b0;
      clr = $urandom_range(0, 9) == 0;
      stl = $urandom_range(0, 9) == 0;
      drive(v, me, we, sz, un, sel, $urandom, $urandom, 5'($urandom), clr, stl);
      checks++; if (result_dm !== exp_res) begin errors++; $display("FAIL rnd_result n=%0d got=%h want=%h", n, result_dm, exp_res); end
      checks++; if (valid_dm !== exp_valid) begin errors++; $display("FAIL rnd_valid n=%0d got=%b want=%b", n, valid_dm, exp_valid); end
      checks++; if (rd_dm !== exp_rd) begin errors++; $display("FAIL rnd_rd n=%0d got=%h want=%h", n, rd_dm, exp_rd); end
      checks++; if (misalign_dm !== exp_mis) begin errors++; $display("FAIL rnd_mis n=%0d got=%b want=%b", n, misalign_dm, exp_mis); end
      checks++; if (err_sticky !== exp_err) begin errors++; $display("FAIL rnd_err n=%0d got=%b want=%b", n, err_sticky, exp_err); end
    end
  endtask

  initial begin
    test_reset();
    init_mem();
    test_word_store_load();
    test_misalign();
    test_set_wins();
    test_stall();
    test_max_addr();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_param.md
MEM_STAGE_PARAM -- requirements
Module: mem_stage_param

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the data word width; legal values are 16, 32 and 64.
REQ-002 The block SHALL have parameter ADDR_W, default 8, giving the byte-address width.
REQ-003 The block SHALL have parameter RD_W, default 5, giving the destination-register index width.
REQ-004 The block SHALL derive DEPTH = 2^(ADDR_W - log2(DATA_W/8)) words as a localparam, which SHALL NOT be overridable.

Ports:
REQ-005 The block SHALL have these ports; reset is asynchronous and active-low:
- clk4  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  freezes the stage.
- valid_ex  in  1  execute-stage slot holds an instruction.
- mem_en_ex  in  1  access memory.
- mem_we_ex  in  1  1 = store, 0 = load.
- size_ex  in  2  00 byte, 01 half, 10 word(32), 11 double(64).
- unsigned_ex  in  1  zero-extend loads.
- mem_sel_ex  in  1  1 = result from memory, 0 = ALU pass.
- ans_ex  in  DATA_W  ALU result; its low ADDR_W bits are the byte address.
- b_bypass  in  DATA_W  store data, right-aligned.
- rd_ex  in  RD_W  destination register.
- err_clr  in  1  clears err_sticky.
- valid_dm  out  1  result slot valid.
- rd_dm  out  RD_W  registered destination.
- result_dm  out  DATA_W  stage result.
- misalign_dm  out  1  registered per-access alignment error.
- err_sticky  out  1  latched alignment error.

Function
REQ-006 Latency SHALL be one clk4 edge: inputs sampled at edge N appear on the outputs after edge N.
REQ-007 When stall=1, the block SHALL hold all registers and disable the RAM enable; result_dm SHALL remain unchanged.
REQ-008 An access SHALL occur only when valid_ex=1, mem_en_ex=1 and stall=0.
REQ-009 Memory SHALL be little-endian with a synchronous read; a word index is addr >> log2(DATA_W/8).
REQ-010 Alignment rules: a half access requires addr[0]=0, a word access requires addr[1:0]=0, and a double access requires addr[2:0]=0.
REQ-011 Any size whose width exceeds DATA_W SHALL be misaligned.
REQ-012 A misaligned access SHALL suppress the write and return a load result of 0.
REQ-013 A misaligned access SHALL set misalign_dm=1 for one cycle and set err_sticky.
REQ-014 A store SHALL write only the byte lanes selected by size and offset, and SHALL place b_bypass low bytes on those lanes.
REQ-015 A load SHALL select lanes using the registered offset and size, then sign-extend (unsigned_ex=0) or zero-extend (unsigned_ex=1) to DATA_W.
REQ-016 If mem_sel_ex=1 and mem_we_ex=0, result_dm SHALL be the extended load data; otherwise result_dm SHALL be the registered ans_ex.
REQ-017 valid_dm SHALL equal the registered valid_ex; rd_dm SHALL equal the registered rd_ex.
REQ-018 A load at edge N+1 to an address stored at edge N SHALL return the new data; no forwarding path is needed because the RAM is written first.
REQ-019 A simultaneous store and read on the same edge is impossible, since there is a single port.
REQ-020 If err_clr=1 and a new misalignment occur on the same edge, err_sticky SHALL end at 1 (set wins).
REQ-021 Address wrap: an address outside DEPTH is impossible by construction; the maximum address SHALL map to the last word.

Reset
REQ-022 While rst_n=0, outputs SHALL be: valid_dm=0, rd_dm=0, result_dm=0 (registered ALU value 0, memory-select register 0), misalign_dm=0, err_sticky=0.
REQ-023 RAM writes SHALL be gated by rst_n, so a store coincident with reset assertion is not performed.
REQ-024 RAM contents SHALL NOT be reset.

Structure
REQ-025 A shared package SHALL hold the size-code constants (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DBL) and a byte-enable generation function.
REQ-026 The block SHALL contain one sub-module, dm_ram: a single-port synchronous RAM with per-byte write enables and an output that holds when disabled.

Verification
REQ-027 Word store then load: store 0xDEADBEEF to addr 0x10, then load a word from 0x10 -> result_dm=0xDEADBEEF one edge later, with valid_dm=1.
REQ-028 Byte load extension: after REQ-027, load a byte from 0x13 signed -> 0xFFFFFFDE; load the same byte unsigned -> 0x000000DE.
REQ-029 Half store: store half 0x1234 to 0x12, then load a word from 0x10 -> 0x1234BEEF.
REQ-030 Misalignment: load a word from 0x11 -> misalign_dm=1, result_dm=0, err_sticky=1; memory unchanged; err_clr pulse -> err_sticky=0.
REQ-031 Stall: assert stall for 3 cycles during a load -> outputs frozen and no RAM access; release -> the load completes with correct data.
REQ-032 Reset mid-operation: assert rst_n=0 during a store to 0x20 -> all outputs 0; a later load from 0x20 returns the prior contents.
